// File: rtl/mem_ctrl.sv
// Responder for the MEM-stage RAM request port and the IF fetch port: arbitrates,
// serialises each 32-bit request into byte accesses on the external RAM, pulses done.
module mem_ctrl #(
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ram_r_req,
    input  logic              ram_w_req,
    input  logic [ADDR_W-1:0] ram_addr,
    input  logic [31:0]       ram_w_data,
    input  logic [3:0]        buffer_pointer,
    output logic [31:0]       ram_r_data,
    output logic              ram_done,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [31:0]       if_data,
    output logic              if_done,
    input  logic [7:0]        mem_din,
    output logic [7:0]        mem_dout,
    output logic [ADDR_W-1:0] mem_a,
    output logic              mem_wr
);

    localparam int unsigned CNT_W = 3;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             r_state,   w_state_nxt;
    logic [CNT_W-1:0]   r_cnt,     w_cnt_nxt;
    logic [CNT_W-1:0]   r_len,     w_len_nxt;
    logic [ADDR_W-1:0]  r_base,    w_base_nxt;
    logic [31:0]        r_wdata,   w_wdata_nxt;
    logic               r_port_if, w_port_if_nxt;
    logic [CNT_W-1:0]   w_st_len;

    logic [ADDR_W-1:0]  r_mem_a,    w_mem_a_nxt;
    logic [7:0]         r_mem_dout, w_mem_dout_nxt;
    logic               r_mem_wr,   w_mem_wr_nxt;
    logic               r_ram_done, w_ram_done_nxt;
    logic               r_if_done,  w_if_done_nxt;
    logic [31:0]        r_ram_r_data;
    logic [31:0]        r_if_data;
    logic               w_cap;
    logic [1:0]         w_cap_idx;

    // Store length in bytes from the buffer pointer code; upper bits are don't-care.
    always_comb begin
        w_st_len = CNT_W'(1);
        casez (buffer_pointer)
            4'b??00: w_st_len = CNT_W'(4);
            4'b??01: w_st_len = CNT_W'(3);
            4'b??10: w_st_len = CNT_W'(2);
            default: w_st_len = CNT_W'(1);
        endcase
    end

    // State and transaction context registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_len     <= '0;
            r_base    <= '0;
            r_wdata   <= '0;
            r_port_if <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_len     <= w_len_nxt;
            r_base    <= w_base_nxt;
            r_wdata   <= w_wdata_nxt;
            r_port_if <= w_port_if_nxt;
        end
    end

    // Next state: data port (store over load) beats fetch; requests only sampled in IDLE.
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_len_nxt     = r_len;
        w_base_nxt    = r_base;
        w_wdata_nxt   = r_wdata;
        w_port_if_nxt = r_port_if;
        unique case (r_state)
            S_IDLE: begin
                w_cnt_nxt = '0;
                if (ram_w_req) begin
                    w_state_nxt   = S_WRITE;
                    w_base_nxt    = ram_addr;
                    w_wdata_nxt   = ram_w_data;
                    w_len_nxt     = w_st_len;
                    w_port_if_nxt = 1'b0;
                end else if (ram_r_req) begin
                    w_state_nxt   = S_READ;
                    w_base_nxt    = ram_addr;
                    w_len_nxt     = CNT_W'(4);
                    w_port_if_nxt = 1'b0;
                end else if (if_req) begin
                    w_state_nxt   = S_READ;
                    w_base_nxt    = if_addr;
                    w_len_nxt     = CNT_W'(4);
                    w_port_if_nxt = 1'b1;
                end
            end
            S_READ: begin
                // Count 4 is the trailing capture-only cycle.
                if (r_cnt == CNT_W'(4)) begin
                    w_state_nxt = S_DONE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            S_WRITE: begin
                if (r_cnt == r_len - CNT_W'(1)) begin
                    w_state_nxt = S_DONE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Outputs for the coming cycle, derived from the next state so they can be registered.
    always_comb begin
        w_mem_a_nxt    = '0;
        w_mem_dout_nxt = '0;
        w_mem_wr_nxt   = 1'b0;
        w_ram_done_nxt = 1'b0;
        w_if_done_nxt  = 1'b0;
        unique case (w_state_nxt)
            S_READ: begin
                if (w_cnt_nxt != CNT_W'(4)) begin
                    w_mem_a_nxt = w_base_nxt + ADDR_W'(w_cnt_nxt);
                end
            end
            S_WRITE: begin
                w_mem_a_nxt    = w_base_nxt + ADDR_W'(w_cnt_nxt);
                w_mem_dout_nxt = w_wdata_nxt[{w_cnt_nxt[1:0], 3'b000} +: 8];
                w_mem_wr_nxt   = 1'b1;
            end
            S_DONE: begin
                w_ram_done_nxt = ~w_port_if_nxt;
                w_if_done_nxt  = w_port_if_nxt;
            end
            default: ;
        endcase
    end

    // Read byte for address k arrives while the counter shows k+1.
    assign w_cap     = (r_state == S_READ) && (r_cnt != '0);
    assign w_cap_idx = 2'(r_cnt - CNT_W'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mem_a      <= '0;
            r_mem_dout   <= '0;
            r_mem_wr     <= 1'b0;
            r_ram_done   <= 1'b0;
            r_if_done    <= 1'b0;
            r_ram_r_data <= '0;
            r_if_data    <= '0;
        end else begin
            r_mem_a    <= w_mem_a_nxt;
            r_mem_dout <= w_mem_dout_nxt;
            r_mem_wr   <= w_mem_wr_nxt;
            r_ram_done <= w_ram_done_nxt;
            r_if_done  <= w_if_done_nxt;
            if (w_cap) begin
                if (r_port_if) begin
                    r_if_data[{w_cap_idx, 3'b000} +: 8] <= mem_din;
                end else begin
                    r_ram_r_data[{w_cap_idx, 3'b000} +: 8] <= mem_din;
                end
            end
        end
    end

    assign mem_a      = r_mem_a;
    assign mem_dout   = r_mem_dout;
    assign mem_wr     = r_mem_wr;
    assign ram_done   = r_ram_done;
    assign if_done    = r_if_done;
    assign ram_r_data = r_ram_r_data;
    assign if_data    = r_if_data;

endmodule

// File: tb/tb_mem_ctrl.sv
// Scoreboard bench for mem_ctrl: byte-array RAM model, expected results queued at issue,
// popped and compared by a monitor on each done pulse.
module tb_mem_ctrl;

    localparam int unsigned ADDR_W = 32;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              ram_r_req = 1'b0;
    logic              ram_w_req = 1'b0;
    logic [ADDR_W-1:0] ram_addr = '0;
    logic [31:0]       ram_w_data = '0;
    logic [3:0]        buffer_pointer = '0;
    logic [31:0]       ram_r_data;
    logic              ram_done;
    logic              if_req = 1'b0;
    logic [ADDR_W-1:0] if_addr = '0;
    logic [31:0]       if_data;
    logic              if_done;
    logic [7:0]        mem_din = '0;
    logic [7:0]        mem_dout;
    logic [ADDR_W-1:0] mem_a;
    logic              mem_wr;

    mem_ctrl #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst),
        .ram_r_req(ram_r_req), .ram_w_req(ram_w_req), .ram_addr(ram_addr),
        .ram_w_data(ram_w_data), .buffer_pointer(buffer_pointer),
        .ram_r_data(ram_r_data), .ram_done(ram_done),
        .if_req(if_req), .if_addr(if_addr), .if_data(if_data), .if_done(if_done),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // phys: what the DUT actually wrote; refm: what the requests should have written.
    logic [7:0] phys [logic [31:0]];
    logic [7:0] refm [logic [31:0]];

    function automatic logic [7:0] dflt(input logic [31:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction
    function automatic logic [7:0] phys_rd(input logic [31:0] a);
        return phys.exists(a) ? phys[a] : dflt(a);
    endfunction
    function automatic logic [7:0] ref_rd(input logic [31:0] a);
        return refm.exists(a) ? refm[a] : dflt(a);
    endfunction

    // External byte RAM: write on strobe, read data one cycle after the address.
    always @(posedge clk) begin
        if (mem_wr) phys[mem_a] = mem_dout;
        mem_din <= phys_rd(mem_a);
    end

    typedef struct {
        bit          is_load;
        logic [31:0] addr;
        logic [31:0] data;
        int          done_cyc;
    } exp_t;

    exp_t dq[$];
    exp_t fq[$];

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_done(input bit is_if);
        exp_t e;
        if (is_if ? (fq.size() == 0) : (dq.size() == 0)) begin
            chk32(is_if ? "if_done_unexpected" : "ram_done_unexpected", 32'd1, 32'd0);
            return;
        end
        e = is_if ? fq.pop_front() : dq.pop_front();
        chk32(is_if ? "if_done_cycle" : "ram_done_cycle", 32'(cyc), 32'(e.done_cyc));
        chk32("done_bus_idle", {mem_a[22:0], mem_dout, mem_wr}, 32'd0);
        if (e.is_load) begin
            chk32(is_if ? "if_data" : "ram_r_data", is_if ? if_data : ram_r_data, e.data);
        end else begin
            for (int i = 0; i < 4; i++)
                chk32("store_ram_byte", 32'(phys_rd(e.addr + 32'(i))), 32'(ref_rd(e.addr + 32'(i))));
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (ram_done) check_done(1'b0);
            if (if_done)  check_done(1'b1);
        end
    end

    function automatic logic [31:0] ref_word(input logic [31:0] a);
        return {ref_rd(a + 32'd3), ref_rd(a + 32'd2), ref_rd(a + 32'd1), ref_rd(a)};
    endfunction

    task automatic poke(input logic [31:0] a, input logic [7:0] b);
        phys[a] = b;
        refm[a] = b;
    endtask

    // Issue at a negedge with the DUT idle; that cycle is cycle 0 of the request.
    task automatic run_txn(input bit dw, input bit dr, input bit df,
                           input logic [31:0] da, input logic [31:0] wd,
                           input logic [3:0] bp, input logic [31:0] fa);
        exp_t e;
        int   s, len, lat;
        bit   dpend, fpend;
        s   = cyc;
        len = dw ? (4 - int'(bp[1:0])) : 4;
        lat = dw ? len + 1 : 6;
        if (dw || dr) begin
            if (dw) for (int i = 0; i < len; i++) refm[da + 32'(i)] = wd[8*i +: 8];
            e.is_load  = !dw;
            e.addr     = da;
            e.data     = dw ? wd : ref_word(da);
            e.done_cyc = s + lat;
            dq.push_back(e);
        end
        if (df) begin
            e.is_load  = 1'b1;
            e.addr     = fa;
            e.data     = ref_word(fa);
            e.done_cyc = (dw || dr) ? s + lat + 7 : s + 6;
            fq.push_back(e);
        end
        ram_w_req = dw; ram_r_req = dr; ram_addr = da; ram_w_data = wd;
        buffer_pointer = bp; if_req = df; if_addr = fa;
        dpend = dw || dr;
        fpend = df;
        for (int t = 1; (dpend || fpend) && t <= 40; t++) begin
            @(negedge clk);
            if (dpend && t <= len) begin
                chk32("mem_a_seq", mem_a, da + 32'(t - 1));
                chk32("mem_wr_seq", 32'(mem_wr), 32'(dw));
                if (dw) chk32("mem_dout_seq", 32'(mem_dout), 32'(wd[8*(t-1) +: 8]));
            end
            if (ram_done) begin dpend = 1'b0; ram_w_req = 1'b0; ram_r_req = 1'b0; end
            if (if_done)  begin fpend = 1'b0; if_req = 1'b0; end
        end
        if (dpend || fpend) begin
            chk32("txn_timeout", 32'd1, 32'd0);
            ram_w_req = 1'b0; ram_r_req = 1'b0; if_req = 1'b0;
        end
    endtask

    task automatic gap(input int n);
        repeat (n + 1) @(negedge clk);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        logic [31:0] a, w;
        int s, kind;

        // Reset held three cycles, then ten idle cycles.
        repeat (3) @(negedge clk);
        chk32("reset_outputs", {ram_r_data[28:0], mem_wr, ram_done, if_done}, 32'd0);
        chk32("reset_mem_a", mem_a, 32'd0);
        rst = 1'b0;
        repeat (10) begin
            @(negedge clk);
            chk32("idle_mem_a", mem_a, 32'd0);
            chk32("idle_flags", 32'({mem_wr, ram_done, if_done, mem_dout}), 32'd0);
        end
        chk32("idle_if_data", if_data, 32'd0);

        // Load word.
        poke(32'h100, 8'h78); poke(32'h101, 8'h56); poke(32'h102, 8'h34); poke(32'h103, 8'h12);
        run_txn(1'b0, 1'b1, 1'b0, 32'h100, 32'd0, 4'd0, 32'd0);
        chk32("load_word_value", ram_r_data, 32'h12345678);
        gap(0);

        // SB, SH, SW.
        run_txn(1'b1, 1'b0, 1'b0, 32'h200, 32'hAABBCCDD, 4'd3, 32'd0); gap(1);
        run_txn(1'b1, 1'b0, 1'b0, 32'h200, 32'hAABBCCDD, 4'd2, 32'd0); gap(0);
        run_txn(1'b1, 1'b0, 1'b0, 32'h200, 32'hAABBCCDD, 4'd0, 32'd0); gap(2);

        // Arbitration: data load first, fetch afterwards.
        run_txn(1'b0, 1'b1, 1'b1, 32'h100, 32'd0, 4'd0, 32'h0);
        chk32("loaded_word_kept", ram_r_data, 32'h12345678);
        gap(0);

        // Async reset during byte 2 of a SW.
        s = cyc;
        refm[32'h300] = 8'h11; refm[32'h301] = 8'h22;
        ram_w_req = 1'b1; ram_addr = 32'h300; ram_w_data = 32'h44332211; buffer_pointer = 4'd0;
        repeat (3) @(negedge clk);
        chk32("abort_pre_wr", 32'(mem_wr), 32'd1);
        chk32("abort_pre_a", mem_a, 32'h302);
        rst = 1'b1;
        #1;
        chk32("abort_mem_wr_async", 32'(mem_wr), 32'd0);
        chk32("abort_mem_a_async", mem_a, 32'd0);
        ram_w_req = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk32("abort_no_done", 32'({ram_done, if_done}), 32'd0);
        end
        chk32("abort_rdata_cleared", ram_r_data, 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 4; i++)
            chk32("abort_ram_byte", 32'(phys_rd(32'h300 + 32'(i))), 32'(ref_rd(32'h300 + 32'(i))));
        gap(0);
        run_txn(1'b1, 1'b0, 1'b0, 32'h300, 32'hDEADBEEF, 4'd3, 32'd0); gap(0);

        // Address wrap for load and store.
        run_txn(1'b0, 1'b1, 1'b0, 32'hFFFFFFFE, 32'd0, 4'd0, 32'd0); gap(0);
        run_txn(1'b1, 1'b0, 1'b0, 32'hFFFFFFFF, 32'h0BADF00D, 4'd0, 32'd0); gap(0);
        run_txn(1'b0, 1'b0, 1'b1, 32'd0, 32'd0, 4'd0, 32'hFFFFFFFD); gap(0);

        // Randomized mix over two small overlapping regions.
        for (int n = 0; n < 60; n++) begin
            kind = int'($urandom_range(0, 4));
            a = ($urandom_range(0, 1) != 0 ? 32'hFFFFFFF0 : 32'h400) + 32'($urandom_range(0, 31));
            w = $urandom;
            case (kind)
                0: run_txn(1'b0, 1'b1, 1'b0, a, 32'd0, 4'd0, 32'd0);
                1: run_txn(1'b1, 1'b0, 1'b0, a, w, 4'($urandom_range(0, 3)), 32'd0);
                2: run_txn(1'b0, 1'b0, 1'b1, 32'd0, 32'd0, 4'd0, a);
                3: run_txn(1'b0, 1'b1, 1'b1, a, 32'd0, 4'd0, a ^ 32'h4);
                default: run_txn(1'b1, 1'b0, 1'b1, a, w, 4'($urandom_range(0, 3)), a + 32'd1);
            endcase
            gap(int'($urandom_range(0, 2)));
        end

        repeat (4) @(negedge clk);
        chk32("data_queue_drained", 32'(dq.size()), 32'd0);
        chk32("fetch_queue_drained", 32'(fq.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
